// File: rtl/keyboard_pkg.sv
// Shared constants, state encoding and ASCII decode for the keyboard serial link.
// Both the transmitter and receiver sides import this package.
package keyboard_pkg;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_9 = 8'h39;
    localparam logic [7:0] ASCII_U = 8'h75;
    localparam logic [3:0] CODE_U  = 4'hF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4,
        BREAK = 3'd5
    } rx_state_t;

    // Returns {hit, code}; hit is low for any byte outside the table.
    function automatic logic [4:0] ascii_to_code(input logic [7:0] ch);
        logic [4:0] result;
        result = 5'h00;
        if ((ch >= ASCII_0) && (ch <= ASCII_9)) begin
            result = {1'b1, ch[3:0]};
        end else if (ch == ASCII_U) begin
            result = {1'b1, CODE_U};
        end else begin
            result = 5'h00;
        end
        return result;
    endfunction

endpackage

// File: rtl/keyboard_rx_if.sv
// Serial line in, decoded switch code and strobes out.
// The master side drives the line; the slave side is the receiver.
interface keyboard_rx_if;
    logic       rx;
    logic [3:0] code;
    logic       code_valid;
    logic       unknown;
    logic       frame_err;

    modport master (output rx, input code, code_valid, unknown, frame_err);
    modport slave  (input rx, output code, code_valid, unknown, frame_err);
endinterface

// File: rtl/keyboard_rx_cereal_rx.sv
// 8N1 UART deserialiser: input synchroniser, bit-timing FSM and shift register.
// byte_valid is a combinational strobe on the good stop sample so the decoded code can register on the same edge.
module cereal_rx
    import keyboard_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rxs_s;
    rx_state_t              state_r;
    logic [CNT_W-1:0]       baud_cnt_r;
    logic [2:0]             bit_cnt_r;
    logic [7:0]             shift_r;
    logic                   frame_err_r;

    assign rxs_s      = sync_r[SYNC_STAGES-1];
    assign rx_byte    = shift_r;
    assign frame_err  = frame_err_r;
    assign byte_valid = (state_r == STOP) && (baud_cnt_r == BAUD_MAX) && rxs_s;

    // Synchroniser, frame FSM, baud/bit counters and data shift register.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync_r      <= '1;
            state_r     <= IDLE;
            baud_cnt_r  <= '0;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            frame_err_r <= 1'b0;
        end else begin
            sync_r      <= {sync_r[SYNC_STAGES-2:0], rx};
            frame_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= '0;
                    if (!rxs_s) begin
                        bit_cnt_r <= 3'd0;
                        state_r   <= START;
                    end
                end
                START: begin
                    if (baud_cnt_r == BAUD_HALF) begin
                        baud_cnt_r <= '0;
                        // A start bit that is gone by mid-bit was a glitch.
                        state_r    <= rxs_s ? IDLE : DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_cnt_r == BAUD_MAX) begin
                        baud_cnt_r <= '0;
                        shift_r    <= {rxs_s, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            bit_cnt_r <= 3'd0;
                            state_r   <= STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (baud_cnt_r == BAUD_MAX) begin
                        baud_cnt_r <= '0;
                        if (rxs_s) begin
                            state_r <= DONE;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= BREAK;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                BREAK: begin
                    // Hold here until the line recovers so a stuck-low line reports once.
                    if (rxs_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/keyboard_rx.sv
// Keyboard link receiver: deserialises frames and decodes ASCII back to 4-bit switch codes.
// code holds the last good decode; code_valid/unknown/frame_err are single-cycle strobes.
module keyboard_rx
    import keyboard_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic          sysclk,
    input  logic          rst,
    keyboard_rx_if.slave  bus
);

    logic [7:0] rx_byte_s;
    logic       byte_valid_s;
    logic       frame_err_s;
    logic [4:0] dec_s;
    logic [3:0] code_r;
    logic       code_valid_r;
    logic       unknown_r;

    cereal_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_cereal_rx (
        .sysclk     (sysclk),
        .rst        (rst),
        .rx         (bus.rx),
        .rx_byte    (rx_byte_s),
        .byte_valid (byte_valid_s),
        .frame_err  (frame_err_s)
    );

    assign dec_s = ascii_to_code(rx_byte_s);

    // Register the decoded code and its strobes on the good stop sample.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            code_r       <= 4'h0;
            code_valid_r <= 1'b0;
            unknown_r    <= 1'b0;
        end else begin
            code_valid_r <= 1'b0;
            unknown_r    <= 1'b0;
            if (byte_valid_s) begin
                if (dec_s[4]) begin
                    code_r       <= dec_s[3:0];
                    code_valid_r <= 1'b1;
                end else begin
                    unknown_r <= 1'b1;
                end
            end
        end
    end

    assign bus.code       = code_r;
    assign bus.code_valid = code_valid_r;
    assign bus.unknown    = unknown_r;
    assign bus.frame_err  = frame_err_s;

endmodule
